// File: rtl/board_ctl_pkg.sv
// Shared playfield geometry and controller state encoding for the board
// responder and the renderer.
package board_ctl_pkg;

  localparam int unsigned X0    = 201;
  localparam int unsigned Y0    = 10;
  localparam int unsigned CELL  = 35;
  localparam int unsigned COLS  = 10;
  localparam int unsigned ROWS  = 20;
  localparam int unsigned COL_W = 4;
  localparam int unsigned ROW_W = 5;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/board_ctl_if.sv
// Controller/renderer bundle for the board responder: position, lock
// request, cell read port and status outputs.
interface board_ctl_if;
  import board_ctl_pkg::*;

  logic [11:0]      xpos;
  logic [11:0]      ypos;
  logic             lock_req;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic             rd_cell;
  logic             blocked_left;
  logic             blocked_right;
  logic             blocked_down;
  logic             pos_err;
  logic             busy;
  logic [15:0]      lines;
  logic             game_over;

  modport master (
    output xpos, ypos, lock_req, rd_col, rd_row,
    input  rd_cell, blocked_left, blocked_right, blocked_down,
           pos_err, busy, lines, game_over
  );

  modport slave (
    input  xpos, ypos, lock_req, rd_col, rd_row,
    output rd_cell, blocked_left, blocked_right, blocked_down,
           pos_err, busy, lines, game_over
  );

endinterface

// File: rtl/board_ctl_pix_to_cell.sv
// Pixel coordinate to cell index. A compare ladder against BASE + k*CELL
// replaces a divider; only exact cell-aligned coordinates are valid.
module pix_to_cell #(
  parameter int unsigned BASE = 0,
  parameter int unsigned CELL = 1,
  parameter int unsigned N    = 1,
  parameter int unsigned IW   = 1
) (
  input  logic [11:0]   pix,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [11:0] off;

  // Offset is only meaningful when pix >= BASE; the ladder is gated by that.
  always_comb begin
    off   = pix - 12'(BASE);
    idx   = '0;
    valid = 1'b0;
    if (pix >= 12'(BASE)) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (off == 12'(k * CELL)) begin
          idx   = IW'(k);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/board_ctl.sv
// Playfield responder: decodes block position to a grid cell, reports move
// permission, locks blocks into the 10x20 grid and clears full rows.
module board_ctl (
  input  logic       pclk,
  input  logic       rst,
  board_ctl_if.slave bus
);
  import board_ctl_pkg::*;

  logic [COL_W-1:0] col_c;
  logic [ROW_W-1:0] row_c;
  logic             col_ok;
  logic             row_ok;
  logic             pos_ok;

  logic [COLS-1:0]  grid [ROWS];

  state_t           state;
  state_t           state_nx;
  logic [ROW_W-1:0] lat_row;
  logic [COL_W-1:0] lat_col;
  logic [ROW_W-1:0] scan_row;
  logic [ROW_W-1:0] shift_row;
  logic [15:0]      lines_q;
  logic             game_over_q;
  logic             busy_c;
  logic             row_full;

  logic             left_c;
  logic             right_c;
  logic             down_c;
  logic             hold_c;
  logic             rd_ok;

  pix_to_cell #(.BASE(X0), .CELL(CELL), .N(COLS), .IW(COL_W)) u_x (
    .pix   (bus.xpos),
    .idx   (col_c),
    .valid (col_ok)
  );

  pix_to_cell #(.BASE(Y0), .CELL(CELL), .N(ROWS), .IW(ROW_W)) u_y (
    .pix   (bus.ypos),
    .idx   (row_c),
    .valid (row_ok)
  );

  assign pos_ok        = col_ok && row_ok;
  assign bus.busy      = busy_c;
  assign bus.lines     = lines_q;
  assign bus.game_over = game_over_q;

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode for the lock / scan / shift sequence.
  always_comb begin
    state_nx = state;
    busy_c   = (state != ST_IDLE);
    row_full = &grid[scan_row];
    case (state)
      ST_IDLE:  if (bus.lock_req && pos_ok && !game_over_q) state_nx = ST_LOCK;
      ST_LOCK:  state_nx = ST_SCAN;
      ST_SCAN: begin
        if (row_full)               state_nx = ST_SHIFT;
        else if (scan_row == '0)    state_nx = ST_DONE;
      end
      ST_SHIFT: if (shift_row == '0) state_nx = ST_SCAN;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Grid, row counters, line count and game-over flag.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROWS; r++) grid[r] <= '0;
      lat_row     <= '0;
      lat_col     <= '0;
      scan_row    <= '0;
      shift_row   <= '0;
      lines_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          lat_row <= row_c;
          lat_col <= col_c;
        end
        ST_LOCK: begin
          if (grid[lat_row][lat_col]) game_over_q <= 1'b1;
          grid[lat_row][lat_col] <= 1'b1;
          scan_row <= LAST_ROW;
        end
        ST_SCAN: begin
          if (row_full)             shift_row <= scan_row;
          else if (scan_row != '0)  scan_row  <= scan_row - ROW_W'(1);
        end
        ST_SHIFT: begin
          // Row 0 takes zeros and ends the clear; scan_row is left alone so
          // the row that just moved into it is rescanned.
          if (shift_row == '0) begin
            grid[0] <= '0;
            if (lines_q != '1) lines_q <= lines_q + 16'd1;
          end else begin
            grid[shift_row] <= grid[shift_row - ROW_W'(1)];
            shift_row       <= shift_row - ROW_W'(1);
          end
        end
        ST_DONE: if (|grid[0]) game_over_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Neighbour lookups; edge tests short-circuit out-of-range indices.
  always_comb begin
    left_c  = (col_c == '0)      || grid[row_c][col_c - COL_W'(1)];
    right_c = (col_c == LAST_COL) || grid[row_c][col_c + COL_W'(1)];
    down_c  = (row_c == LAST_ROW) || grid[row_c + ROW_W'(1)][col_c];
    hold_c  = !pos_ok || busy_c || game_over_q;
    rd_ok   = (bus.rd_row <= LAST_ROW) && (bus.rd_col <= LAST_COL);
  end

  // Registered move flags, position error and renderer read.
  always_ff @(posedge pclk) begin
    if (rst) begin
      bus.blocked_left  <= 1'b0;
      bus.blocked_right <= 1'b0;
      bus.blocked_down  <= 1'b0;
      bus.pos_err       <= 1'b0;
      bus.rd_cell       <= 1'b0;
    end else begin
      bus.blocked_left  <= hold_c || left_c;
      bus.blocked_right <= hold_c || right_c;
      bus.blocked_down  <= hold_c || down_c;
      bus.pos_err       <= !pos_ok;
      bus.rd_cell       <= rd_ok ? grid[bus.rd_row][bus.rd_col] : 1'b0;
    end
  end

endmodule

// File: tb/tb_board_ctl.sv
// Directed bench for board_ctl: position decode, move flags, lock timing,
// row clear with shift-down, misaligned lock rejection and game over.
module tb_board_ctl;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;

  board_ctl_if bus ();

  board_ctl dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1;
    bus.lock_req = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  // Pulse lock_req at (x,y) and count the cycles busy stays high.
  task automatic lock_at(input int x, input int y, output int busy_cycles);
    @(negedge pclk);
    bus.xpos     = 12'(x);
    bus.ypos     = 12'(y);
    bus.lock_req = 1'b1;
    @(negedge pclk);
    bus.lock_req = 1'b0;
    busy_cycles  = 0;
    while (bus.busy === 1'b1 && busy_cycles < 300) begin
      busy_cycles++;
      @(negedge pclk);
    end
    if (busy_cycles >= 300) check("busy_timeout", 32'(busy_cycles), 32'd0);
  endtask

  task automatic read_cell(input int r, input int c, input logic exp, input string tag);
    @(negedge pclk);
    bus.rd_row = 5'(r);
    bus.rd_col = 4'(c);
    @(negedge pclk);
    check(tag, 32'(bus.rd_cell), 32'(exp));
  endtask

  task automatic set_pos(input int x, input int y);
    @(negedge pclk);
    bus.xpos = 12'(x);
    bus.ypos = 12'(y);
    @(negedge pclk);
  endtask

  initial begin
    bus.xpos     = 12'd236;
    bus.ypos     = 12'd10;
    bus.lock_req = 1'b0;
    bus.rd_row   = '0;
    bus.rd_col   = '0;

    // Reset values while rst is held.
    @(negedge pclk);
    @(negedge pclk);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_lines", 32'(bus.lines), 32'd0);
    check("rst_go",    32'(bus.game_over), 32'd0);
    check("rst_bl",    32'(bus.blocked_left), 32'd0);
    check("rst_bd",    32'(bus.blocked_down), 32'd0);
    check("rst_perr",  32'(bus.pos_err), 32'd0);
    check("rst_rd",    32'(bus.rd_cell), 32'd0);
    rst = 1'b0;

    // (236,10) -> col 1 row 0, empty grid.
    set_pos(236, 10);
    check("c1r0_bl",   32'(bus.blocked_left), 32'd0);
    check("c1r0_br",   32'(bus.blocked_right), 32'd0);
    check("c1r0_bd",   32'(bus.blocked_down), 32'd0);
    check("c1r0_perr", 32'(bus.pos_err), 32'd0);
    check("c1r0_lines", 32'(bus.lines), 32'd0);

    // Bottom-left corner.
    set_pos(201, 675);
    check("c0r19_bl", 32'(bus.blocked_left), 32'd1);
    check("c0r19_bd", 32'(bus.blocked_down), 32'd1);
    check("c0r19_br", 32'(bus.blocked_right), 32'd0);

    // Right edge col 9 row 5.
    set_pos(516, 185);
    check("c9r5_br", 32'(bus.blocked_right), 32'd1);
    check("c9r5_bl", 32'(bus.blocked_left), 32'd0);

    // Off-grid positions.
    set_pos(200, 10);
    check("x_below_perr", 32'(bus.pos_err), 32'd1);
    check("x_below_bl",   32'(bus.blocked_left), 32'd1);
    set_pos(551, 10);
    check("col10_perr", 32'(bus.pos_err), 32'd1);
    set_pos(201, 710);
    check("row20_perr", 32'(bus.pos_err), 32'd1);
    set_pos(201, 9);
    check("y_below_perr", 32'(bus.pos_err), 32'd1);

    // Single lock at col 9 row 19: LOCK + 20 scans + DONE.
    lock_at(516, 675, cyc);
    check("lock1_busy", 32'(cyc), 32'd22);
    read_cell(19, 9, 1'b1, "rd_19_9");
    read_cell(19, 8, 1'b0, "rd_19_8");
    check("lock1_lines", 32'(bus.lines), 32'd0);
    read_cell(20, 9, 1'b0, "rd_oob_row");

    // Row clear: row 18 col 0 first, then row 19 cols 0..9.
    do_reset();
    lock_at(201, 640, cyc);
    for (int c = 0; c < 9; c++) lock_at(201 + 35 * c, 675, cyc);
    check("pre_clear_lines", 32'(bus.lines), 32'd0);
    set_pos(236, 675);
    check("row19_c1_bl", 32'(bus.blocked_left), 32'd1);
    check("row19_c1_br", 32'(bus.blocked_right), 32'd1);
    lock_at(516, 675, cyc);
    check("clear_busy", 32'(cyc), 32'd43);
    check("clear_lines", 32'(bus.lines), 32'd1);
    read_cell(19, 0, 1'b1, "rd_shifted_19_0");
    read_cell(19, 9, 1'b0, "rd_cleared_19_9");
    read_cell(18, 0, 1'b0, "rd_vacated_18_0");

    // Misaligned lock is rejected.
    @(negedge pclk);
    bus.xpos     = 12'd240;
    bus.ypos     = 12'd675;
    bus.lock_req = 1'b1;
    @(negedge pclk);
    bus.lock_req = 1'b0;
    check("mis_perr", 32'(bus.pos_err), 32'd1);
    check("mis_busy", 32'(bus.busy), 32'd0);
    check("mis_bd",   32'(bus.blocked_down), 32'd1);
    @(negedge pclk);
    check("mis_busy2", 32'(bus.busy), 32'd0);
    check("mis_lines", 32'(bus.lines), 32'd1);
    read_cell(19, 1, 1'b0, "mis_rd_19_1");

    // Lock in row 0 -> game over.
    lock_at(201, 10, cyc);
    check("go_busy", 32'(cyc), 32'd22);
    check("go_flag", 32'(bus.game_over), 32'd1);
    lock_at(236, 10, cyc);
    check("go_ignored_busy", 32'(cyc), 32'd0);
    read_cell(0, 1, 1'b0, "go_rd_0_1");
    set_pos(236, 185);
    check("go_hold_bl", 32'(bus.blocked_left), 32'd1);
    check("go_hold_br", 32'(bus.blocked_right), 32'd1);

    // Reset clears grid and game over.
    do_reset();
    @(negedge pclk);
    check("post_rst_go", 32'(bus.game_over), 32'd0);
    check("post_rst_lines", 32'(bus.lines), 32'd0);
    read_cell(0, 0, 1'b0, "post_rst_rd_0_0");
    read_cell(19, 0, 1'b0, "post_rst_rd_19_0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
